// File: rtl/gpu_dcr_pkg.sv
// Shared definitions for the device control register bank: FSM states,
// register slot addresses and CTRL/STATUS bit positions.
package gpu_dcr_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } dcr_state_t;

  localparam int unsigned SLOT_THREAD_COUNT = 0;
  localparam int unsigned SLOT_BLOCK_DIM    = 1;
  localparam int unsigned SLOT_BASE_ADDR    = 2;
  localparam int unsigned SLOT_CTRL         = 3;
  localparam int unsigned SLOT_STATUS       = 4;
  localparam int unsigned SLOT_CYC_LO       = 5;
  localparam int unsigned SLOT_CYC_HI       = 6;
  localparam int unsigned SLOT_RESERVED     = 7;

  localparam int CTRL_START  = 0;
  localparam int CTRL_CLEAR  = 1;
  localparam int CTRL_IRQ_EN = 2;

  localparam int STAT_BUSY = 0;
  localparam int STAT_DONE = 1;
  localparam int STAT_ERR  = 2;

endpackage

// File: rtl/dcr_cycle_counter.sv
// Saturating run-cycle counter; clear has priority over enable and the
// count sticks at all-ones instead of wrapping.
module dcr_cycle_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         i_clear,
  input  logic         i_enable,
  output logic [W-1:0] o_count
);

  logic [W-1:0] r_count;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_count <= '0;
    end else if (i_clear) begin
      r_count <= '0;
    end else if (i_enable && (r_count != {W{1'b1}})) begin
      r_count <= r_count + W'(1);
    end
  end

  assign o_count = r_count;

endmodule

// File: rtl/dcr_bank.sv
// Device control register bank: launch configuration registers, launch FSM
// with start/busy/done handshake, run-cycle counter and sticky error / IRQ.
module dcr_bank
  import gpu_dcr_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 3,
  parameter int CYC_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  output logic [DATA_W-1:0] thread_count,
  output logic [DATA_W-1:0] block_dim,
  output logic [DATA_W-1:0] base_addr,
  output logic              kernel_start,
  output logic              kernel_busy,
  input  logic              kernel_done_in,
  output logic              irq
);

  dcr_state_t        r_state;
  logic [DATA_W-1:0] r_thread_count;
  logic [DATA_W-1:0] r_block_dim;
  logic [DATA_W-1:0] r_base_addr;
  logic [DATA_W-1:0] r_rd_data;
  logic              r_rd_valid;
  logic              r_irq_en;
  logic              r_err;
  logic              r_start;

  logic [CYC_W-1:0]  w_cycles;
  logic [DATA_W-1:0] w_rd_mux;
  logic              w_running;
  logic              w_done;
  logic              w_ctrl_wr;
  logic              w_cfg_wr;
  logic              w_start_req;
  logic              w_clear_req;
  logic              w_tc_ok;
  logic              w_launch;
  logic              w_err_set;
  logic              w_err_clr;

  assign w_running   = (r_state == RUN);
  assign w_done      = (r_state == DONE);
  assign w_ctrl_wr   = wr_en && (wr_addr == ADDR_W'(SLOT_CTRL));
  assign w_cfg_wr    = wr_en && ((wr_addr == ADDR_W'(SLOT_THREAD_COUNT)) ||
                                 (wr_addr == ADDR_W'(SLOT_BLOCK_DIM)) ||
                                 (wr_addr == ADDR_W'(SLOT_BASE_ADDR)));
  assign w_start_req = w_ctrl_wr && wr_data[CTRL_START];
  assign w_clear_req = w_ctrl_wr && wr_data[CTRL_CLEAR];
  assign w_tc_ok     = (r_thread_count != '0);
  assign w_launch    = w_start_req && w_tc_ok && !w_running;

  // A rejected start (zero threads) sets err even if clear is requested in the same write.
  assign w_err_set = (w_running && (w_cfg_wr || w_start_req)) ||
                     (w_start_req && !w_tc_ok && !w_running);
  assign w_err_clr = w_clear_req && !w_running;

  dcr_cycle_counter #(
    .W (CYC_W)
  ) u_cycle_counter (
    .clk      (clk),
    .reset    (reset),
    .i_clear  (w_launch),
    .i_enable (w_running),
    .o_count  (w_cycles)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_thread_count <= '0;
      r_block_dim    <= DATA_W'(1);
      r_base_addr    <= '0;
    end else if (wr_en && !w_running) begin
      case (wr_addr)
        ADDR_W'(SLOT_THREAD_COUNT): r_thread_count <= wr_data;
        ADDR_W'(SLOT_BLOCK_DIM):    r_block_dim    <= wr_data;
        ADDR_W'(SLOT_BASE_ADDR):    r_base_addr    <= wr_data;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state  <= IDLE;
      r_err    <= 1'b0;
      r_irq_en <= 1'b0;
      r_start  <= 1'b0;
    end else begin
      r_start <= w_launch;
      if (w_ctrl_wr) begin
        r_irq_en <= wr_data[CTRL_IRQ_EN];
      end
      if (w_err_set) begin
        r_err <= 1'b1;
      end else if (w_err_clr) begin
        r_err <= 1'b0;
      end
      case (r_state)
        IDLE: if (w_launch) r_state <= RUN;
        RUN:  if (kernel_done_in) r_state <= DONE;
        DONE: begin
          if (w_launch) begin
            r_state <= RUN;
          end else if (w_clear_req) begin
            r_state <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  always_comb begin
    w_rd_mux = '0;
    case (rd_addr)
      ADDR_W'(SLOT_THREAD_COUNT): w_rd_mux = r_thread_count;
      ADDR_W'(SLOT_BLOCK_DIM):    w_rd_mux = r_block_dim;
      ADDR_W'(SLOT_BASE_ADDR):    w_rd_mux = r_base_addr;
      ADDR_W'(SLOT_CTRL):         w_rd_mux[CTRL_IRQ_EN] = r_irq_en;
      ADDR_W'(SLOT_STATUS): begin
        w_rd_mux[STAT_BUSY] = w_running;
        w_rd_mux[STAT_DONE] = w_done;
        w_rd_mux[STAT_ERR]  = r_err;
      end
      ADDR_W'(SLOT_CYC_LO):       w_rd_mux = DATA_W'(w_cycles);
      ADDR_W'(SLOT_CYC_HI):       w_rd_mux = DATA_W'(w_cycles >> DATA_W);
      ADDR_W'(SLOT_RESERVED):     w_rd_mux = '0;
      default:                    w_rd_mux = '0;
    endcase
  end

  // Read data holds its last value when no read is issued.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_rd_data  <= '0;
      r_rd_valid <= 1'b0;
    end else begin
      r_rd_valid <= rd_en;
      if (rd_en) begin
        r_rd_data <= w_rd_mux;
      end
    end
  end

  assign rd_data      = r_rd_data;
  assign rd_valid     = r_rd_valid;
  assign thread_count = r_thread_count;
  assign block_dim    = r_block_dim;
  assign base_addr    = r_base_addr;
  assign kernel_start = r_start;
  assign kernel_busy  = w_running;
  assign irq          = w_done && r_irq_en;

endmodule

// File: tb/tb_dcr_bank.sv
// Self-checking bench for dcr_bank: vector table, directed launch/saturation/
// reset sequences, and randomized traffic against a behavioural model.
module tb_dcr_bank;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       wrEn = 1'b0;
  logic [2:0] wrAddr = '0;
  logic [7:0] wrData = '0;
  logic       rdEn = 1'b0;
  logic [2:0] rdAddr = '0;
  logic       kernelDoneIn = 1'b0;
  logic [7:0] rdData;
  logic       rdValid;
  logic [7:0] threadCount;
  logic [7:0] blockDim;
  logic [7:0] baseAddr;
  logic       kernelStart;
  logic       kernelBusy;
  logic       irq;

  int checkCount = 0;
  int errorCount = 0;

  typedef struct {
    bit       we;
    bit [2:0] wa;
    bit [7:0] wd;
    bit       re;
    bit [2:0] ra;
    bit [7:0] expRd;
    bit       expValid;
  } vec_t;

  vec_t vecs[20];

  // Behavioural model state
  logic [7:0] mCfg[3];
  bit         mIrqEn, mErr, mRunning, mFinished, mStart, mRdValid;
  int         mCycles;
  logic [7:0] mRdData;

  always #5 clk = ~clk;

  dcr_bank #(
    .DATA_W (8),
    .ADDR_W (3),
    .CYC_W  (16)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .wr_en          (wrEn),
    .wr_addr        (wrAddr),
    .wr_data        (wrData),
    .rd_en          (rdEn),
    .rd_addr        (rdAddr),
    .rd_data        (rdData),
    .rd_valid       (rdValid),
    .thread_count   (threadCount),
    .block_dim      (blockDim),
    .base_addr      (baseAddr),
    .kernel_start   (kernelStart),
    .kernel_busy    (kernelBusy),
    .kernel_done_in (kernelDoneIn),
    .irq            (irq)
  );

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checkCount++;
    if (actual !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
    end
  endtask

  function automatic void modelReset();
    mCfg[0] = 8'd0;
    mCfg[1] = 8'd1;
    mCfg[2] = 8'd0;
    mIrqEn = 0; mErr = 0; mRunning = 0; mFinished = 0; mStart = 0;
    mRdValid = 0; mCycles = 0; mRdData = 8'd0;
  endfunction

  function automatic logic [7:0] modelRead(input logic [2:0] ra);
    case (ra)
      3'd0, 3'd1, 3'd2: return mCfg[ra];
      3'd3: return mIrqEn ? 8'h04 : 8'h00;
      3'd4: return {5'd0, mErr, mFinished, mRunning};
      3'd5: return 8'(mCycles % 256);
      3'd6: return 8'(mCycles / 256);
      default: return 8'h00;
    endcase
  endfunction

  // One clock edge of the register bank described directly from its rules.
  function automatic void modelStep(input logic we, input logic [2:0] wa, input logic [7:0] wd,
                                    input logic re, input logic [2:0] ra, input logic dn);
    bit wasRunning = mRunning;
    if (re) mRdData = modelRead(ra);
    mRdValid = re;
    mStart = 0;
    if (wasRunning && mCycles < 65535) mCycles++;
    if (wasRunning && dn) begin
      mRunning = 0;
      mFinished = 1;
    end
    if (we && wa <= 3'd2) begin
      if (wasRunning) mErr = 1;
      else mCfg[wa] = wd;
    end else if (we && wa == 3'd3) begin
      mIrqEn = wd[2];
      if (wasRunning) begin
        if (wd[0]) mErr = 1;
      end else begin
        if (wd[1]) begin
          mErr = 0;
          mFinished = 0;
        end
        if (wd[0] && mCfg[0] != 0) begin
          mRunning = 1;
          mFinished = 0;
          mCycles = 0;
          mStart = 1;
        end else if (wd[0]) begin
          mErr = 1;
        end
      end
    end
  endfunction

  task automatic applyStimulus(input logic we, input logic [2:0] wa, input logic [7:0] wd,
                               input logic re, input logic [2:0] ra, input logic dn);
    wrEn = we; wrAddr = wa; wrData = wd; rdEn = re; rdAddr = ra; kernelDoneIn = dn;
    @(posedge clk);
    modelStep(we, wa, wd, re, ra, dn);
    #1;
    wrEn = 1'b0; rdEn = 1'b0; kernelDoneIn = 1'b0;
  endtask

  task automatic idle();
    applyStimulus(1'b0, 3'd0, 8'h00, 1'b0, 3'd0, 1'b0);
  endtask

  task automatic writeReg(input logic [2:0] wa, input logic [7:0] wd);
    applyStimulus(1'b1, wa, wd, 1'b0, 3'd0, 1'b0);
  endtask

  task automatic readCheck(input string name, input logic [2:0] ra, input logic [7:0] expected);
    applyStimulus(1'b0, 3'd0, 8'h00, 1'b1, ra, 1'b0);
    checkOutput(name, {24'd0, rdData}, {24'd0, expected});
  endtask

  task automatic assertResetMidCycle();
    reset = 1'b0;
    #2;
  endtask

  task automatic releaseReset();
    @(negedge clk);
    reset = 1'b1;
  endtask

  initial begin
    vecs[0]  = '{1'b0, 3'd0, 8'h00, 1'b1, 3'd0, 8'h00, 1'b1};
    vecs[1]  = '{1'b0, 3'd0, 8'h00, 1'b1, 3'd1, 8'h01, 1'b1};
    vecs[2]  = '{1'b0, 3'd0, 8'h00, 1'b1, 3'd2, 8'h00, 1'b1};
    vecs[3]  = '{1'b0, 3'd0, 8'h00, 1'b1, 3'd3, 8'h00, 1'b1};
    vecs[4]  = '{1'b0, 3'd0, 8'h00, 1'b1, 3'd4, 8'h00, 1'b1};
    vecs[5]  = '{1'b0, 3'd0, 8'h00, 1'b1, 3'd5, 8'h00, 1'b1};
    vecs[6]  = '{1'b0, 3'd0, 8'h00, 1'b1, 3'd6, 8'h00, 1'b1};
    vecs[7]  = '{1'b0, 3'd0, 8'h00, 1'b1, 3'd7, 8'h00, 1'b1};
    vecs[8]  = '{1'b1, 3'd0, 8'h20, 1'b1, 3'd0, 8'h00, 1'b1};
    vecs[9]  = '{1'b0, 3'd0, 8'h00, 1'b1, 3'd0, 8'h20, 1'b1};
    vecs[10] = '{1'b1, 3'd1, 8'h03, 1'b1, 3'd1, 8'h01, 1'b1};
    vecs[11] = '{1'b0, 3'd0, 8'h00, 1'b1, 3'd1, 8'h03, 1'b1};
    vecs[12] = '{1'b1, 3'd2, 8'h5A, 1'b1, 3'd7, 8'h00, 1'b1};
    vecs[13] = '{1'b0, 3'd0, 8'h00, 1'b1, 3'd2, 8'h5A, 1'b1};
    vecs[14] = '{1'b1, 3'd7, 8'hFF, 1'b1, 3'd7, 8'h00, 1'b1};
    vecs[15] = '{1'b1, 3'd4, 8'hFF, 1'b1, 3'd4, 8'h00, 1'b1};
    vecs[16] = '{1'b1, 3'd3, 8'h04, 1'b1, 3'd3, 8'h00, 1'b1};
    vecs[17] = '{1'b0, 3'd0, 8'h00, 1'b1, 3'd3, 8'h04, 1'b1};
    vecs[18] = '{1'b1, 3'd3, 8'h00, 1'b0, 3'd3, 8'h04, 1'b0};
    vecs[19] = '{1'b0, 3'd0, 8'h00, 1'b1, 3'd3, 8'h00, 1'b1};

    #1 reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset rd_data", {24'd0, rdData}, 32'h0);
    checkOutput("reset rd_valid", {31'd0, rdValid}, 32'h0);
    checkOutput("reset block_dim", {24'd0, blockDim}, 32'h1);
    checkOutput("reset thread_count", {24'd0, threadCount}, 32'h0);
    checkOutput("reset irq", {31'd0, irq}, 32'h0);
    checkOutput("reset busy", {31'd0, kernelBusy}, 32'h0);
    reset = 1'b1;

    for (int i = 0; i < 20; i++) begin
      applyStimulus(vecs[i].we, vecs[i].wa, vecs[i].wd, vecs[i].re, vecs[i].ra, 1'b0);
      checkOutput($sformatf("vec%0d rd_data", i), {24'd0, rdData}, {24'd0, vecs[i].expRd});
      checkOutput($sformatf("vec%0d rd_valid", i), {31'd0, rdValid}, {31'd0, vecs[i].expValid});
      checkOutput($sformatf("vec%0d busy", i), {31'd0, kernelBusy}, 32'h0);
      checkOutput($sformatf("vec%0d irq", i), {31'd0, irq}, 32'h0);
    end
    checkOutput("cfg block_dim", {24'd0, blockDim}, 32'h03);
    checkOutput("cfg base_addr", {24'd0, baseAddr}, 32'h5A);

    // Launch with irq enabled, done on the tenth edge after the launch edge
    writeReg(3'd3, 8'h05);
    checkOutput("launch start", {31'd0, kernelStart}, 32'h1);
    checkOutput("launch busy", {31'd0, kernelBusy}, 32'h1);
    idle();
    checkOutput("start one cycle", {31'd0, kernelStart}, 32'h0);
    repeat (8) idle();
    checkOutput("still busy", {31'd0, kernelBusy}, 32'h1);
    applyStimulus(1'b0, 3'd0, 8'h00, 1'b0, 3'd0, 1'b1);
    checkOutput("done busy", {31'd0, kernelBusy}, 32'h0);
    checkOutput("done irq", {31'd0, irq}, 32'h1);
    readCheck("done status", 3'd4, 8'h02);
    readCheck("done cyc_lo", 3'd5, 8'd10);
    readCheck("done cyc_hi", 3'd6, 8'd0);
    writeReg(3'd3, 8'h02);
    checkOutput("clear irq", {31'd0, irq}, 32'h0);
    readCheck("clear status", 3'd4, 8'h00);

    // Config write during RUN is discarded and flagged
    writeReg(3'd3, 8'h01);
    idle();
    writeReg(3'd0, 8'h40);
    checkOutput("run write tc", {24'd0, threadCount}, 32'h20);
    readCheck("run err status", 3'd4, 8'h05);
    applyStimulus(1'b0, 3'd0, 8'h00, 1'b0, 3'd0, 1'b1);
    readCheck("done err status", 3'd4, 8'h06);
    writeReg(3'd3, 8'h02);
    readCheck("err cleared", 3'd4, 8'h00);

    // Start with zero threads
    writeReg(3'd0, 8'h00);
    writeReg(3'd3, 8'h01);
    checkOutput("zero start pulse", {31'd0, kernelStart}, 32'h0);
    checkOutput("zero start busy", {31'd0, kernelBusy}, 32'h0);
    readCheck("zero start status", 3'd4, 8'h04);
    writeReg(3'd3, 8'h02);

    // Counter saturation and restart from DONE
    writeReg(3'd0, 8'h01);
    writeReg(3'd3, 8'h01);
    checkOutput("sat start", {31'd0, kernelStart}, 32'h1);
    repeat (65540) idle();
    checkOutput("sat busy", {31'd0, kernelBusy}, 32'h1);
    applyStimulus(1'b0, 3'd0, 8'h00, 1'b0, 3'd0, 1'b1);
    readCheck("sat cyc_lo", 3'd5, 8'hFF);
    readCheck("sat cyc_hi", 3'd6, 8'hFF);
    writeReg(3'd3, 8'h01);
    checkOutput("restart start", {31'd0, kernelStart}, 32'h1);
    checkOutput("restart busy", {31'd0, kernelBusy}, 32'h1);
    readCheck("restart cyc_lo", 3'd5, 8'h00);
    checkOutput("restart pulse end", {31'd0, kernelStart}, 32'h0);
    readCheck("restart cyc_hi", 3'd6, 8'h00);

    // Reset in the middle of RUN
    assertResetMidCycle();
    checkOutput("midrst busy", {31'd0, kernelBusy}, 32'h0);
    checkOutput("midrst thread_count", {24'd0, threadCount}, 32'h0);
    checkOutput("midrst block_dim", {24'd0, blockDim}, 32'h1);
    checkOutput("midrst start", {31'd0, kernelStart}, 32'h0);
    releaseReset();
    applyStimulus(1'b0, 3'd0, 8'h00, 1'b0, 3'd0, 1'b1);
    checkOutput("late done busy", {31'd0, kernelBusy}, 32'h0);
    checkOutput("late done irq", {31'd0, irq}, 32'h0);
    readCheck("late done status", 3'd4, 8'h00);

    // Randomized traffic against the model
    assertResetMidCycle();
    releaseReset();
    modelReset();
    for (int i = 0; i < 2000; i++) begin
      logic       we, re, dn;
      logic [2:0] wa, ra;
      logic [7:0] wd;
      we = ($urandom_range(0, 99) < 35);
      wa = 3'($urandom_range(0, 7));
      wd = 8'($urandom_range(0, 255));
      if (wa == 3'd0 && $urandom_range(0, 3) == 0) wd = 8'h00;
      re = 1'($urandom_range(0, 1));
      ra = 3'($urandom_range(0, 7));
      dn = ($urandom_range(0, 99) < 10);
      applyStimulus(we, wa, wd, re, ra, dn);
      checkOutput("rand rd_data", {24'd0, rdData}, {24'd0, mRdData});
      checkOutput("rand rd_valid", {31'd0, rdValid}, {31'd0, mRdValid});
      checkOutput("rand thread_count", {24'd0, threadCount}, {24'd0, mCfg[0]});
      checkOutput("rand block_dim", {24'd0, blockDim}, {24'd0, mCfg[1]});
      checkOutput("rand base_addr", {24'd0, baseAddr}, {24'd0, mCfg[2]});
      checkOutput("rand start", {31'd0, kernelStart}, {31'd0, mStart});
      checkOutput("rand busy", {31'd0, kernelBusy}, {31'd0, mRunning});
      checkOutput("rand irq", {31'd0, irq}, {31'd0, (mFinished & mIrqEn)});
    end

    $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
    $finish;
  end

endmodule
